// File: rtl/fft_peak_analyzer_if.sv
// Frame/result bus of the FFT peak analyzer: one 16-bin frame strobe in, peak index and status out.
interface fft_peak_analyzer_if;
    logic        fft_valid;
    logic [31:0] fft_d0;
    logic [31:0] fft_d1;
    logic [31:0] fft_d2;
    logic [31:0] fft_d3;
    logic [31:0] fft_d4;
    logic [31:0] fft_d5;
    logic [31:0] fft_d6;
    logic [31:0] fft_d7;
    logic [31:0] fft_d8;
    logic [31:0] fft_d9;
    logic [31:0] fft_d10;
    logic [31:0] fft_d11;
    logic [31:0] fft_d12;
    logic [31:0] fft_d13;
    logic [31:0] fft_d14;
    logic [31:0] fft_d15;
    logic        busy;
    logic        done;
    logic [3:0]  freq;
    logic        drop;

    modport master (
        output fft_valid,
        output fft_d0, fft_d1, fft_d2,  fft_d3,  fft_d4,  fft_d5,  fft_d6,  fft_d7,
        output fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
        input  busy, done, freq, drop
    );

    modport slave (
        input  fft_valid,
        input  fft_d0, fft_d1, fft_d2,  fft_d3,  fft_d4,  fft_d5,  fft_d6,  fft_d7,
        input  fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
        output busy, done, freq, drop
    );
endinterface

// File: rtl/fft_peak_analyzer.sv
// Finds the highest-power bin of a captured 16-bin complex frame, one bin per clock,
// and reports its index 16 edges after the frame was accepted.
module fft_peak_analyzer (
    input  logic                      clk,
    input  logic                      rst,
    fft_peak_analyzer_if.slave        bus
);
    localparam int unsigned NUM_BINS = 16;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned PART_W   = 16;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned PWR_W    = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [WORD_W-1:0]       r_frame [NUM_BINS];
    logic [WORD_W-1:0]       w_in_words [NUM_BINS];
    logic [IDX_W-1:0]        r_bin_cnt;
    logic [IDX_W-1:0]        w_bin_cnt_nxt;
    logic [PWR_W-1:0]        r_max_pwr;
    logic [PWR_W-1:0]        w_max_pwr_nxt;
    logic [IDX_W-1:0]        r_max_idx;
    logic [IDX_W-1:0]        w_max_idx_nxt;
    logic [IDX_W-1:0]        r_freq;
    logic [IDX_W-1:0]        w_freq_nxt;
    logic                    r_done;
    logic                    w_done_nxt;
    logic                    r_drop;
    logic                    w_drop_nxt;
    logic                    r_busy;
    logic                    w_busy_nxt;
    logic                    w_capture;

    logic [WORD_W-1:0]       w_bin_word;
    logic signed [PART_W-1:0] w_re;
    logic signed [PART_W-1:0] w_im;
    logic signed [PWR_W-1:0] w_re_ext;
    logic signed [PWR_W-1:0] w_im_ext;
    logic signed [PWR_W-1:0] w_re_sq;
    logic signed [PWR_W-1:0] w_im_sq;
    logic [PWR_W-1:0]        w_pwr;
    logic                    w_take;
    logic [IDX_W-1:0]        w_win_idx;

    assign w_in_words[0]  = bus.fft_d0;
    assign w_in_words[1]  = bus.fft_d1;
    assign w_in_words[2]  = bus.fft_d2;
    assign w_in_words[3]  = bus.fft_d3;
    assign w_in_words[4]  = bus.fft_d4;
    assign w_in_words[5]  = bus.fft_d5;
    assign w_in_words[6]  = bus.fft_d6;
    assign w_in_words[7]  = bus.fft_d7;
    assign w_in_words[8]  = bus.fft_d8;
    assign w_in_words[9]  = bus.fft_d9;
    assign w_in_words[10] = bus.fft_d10;
    assign w_in_words[11] = bus.fft_d11;
    assign w_in_words[12] = bus.fft_d12;
    assign w_in_words[13] = bus.fft_d13;
    assign w_in_words[14] = bus.fft_d14;
    assign w_in_words[15] = bus.fft_d15;

    // Each square is at most 2^30, so the sum (max 2^31) fits unsigned 32 bits.
    assign w_bin_word = r_frame[r_bin_cnt];
    assign w_re       = w_bin_word[WORD_W-1:PART_W];
    assign w_im       = w_bin_word[PART_W-1:0];
    assign w_re_ext   = PWR_W'(w_re);
    assign w_im_ext   = PWR_W'(w_im);
    assign w_re_sq    = w_re_ext * w_re_ext;
    assign w_im_sq    = w_im_ext * w_im_ext;
    assign w_pwr      = $unsigned(w_re_sq) + $unsigned(w_im_sq);

    // Bin 0 seeds the running maximum; strict compare keeps the lowest index on ties.
    assign w_take    = (r_bin_cnt == '0) || (w_pwr > r_max_pwr);
    assign w_win_idx = w_take ? r_bin_cnt : r_max_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bin_cnt_nxt = r_bin_cnt;
        w_max_pwr_nxt = r_max_pwr;
        w_max_idx_nxt = r_max_idx;
        w_freq_nxt    = r_freq;
        w_done_nxt    = 1'b0;
        w_drop_nxt    = 1'b0;
        w_busy_nxt    = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.fft_valid) begin
                    w_capture     = 1'b1;
                    w_bin_cnt_nxt = '0;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = CALC;
                end
            end
            CALC: begin
                w_busy_nxt = 1'b1;
                w_drop_nxt = bus.fft_valid;
                if (w_take) begin
                    w_max_pwr_nxt = w_pwr;
                    w_max_idx_nxt = r_bin_cnt;
                end
                w_bin_cnt_nxt = r_bin_cnt + IDX_W'(1);
                if (r_bin_cnt == IDX_W'(NUM_BINS - 1)) begin
                    w_freq_nxt    = w_win_idx;
                    w_done_nxt    = 1'b1;
                    w_busy_nxt    = 1'b0;
                    w_bin_cnt_nxt = '0;
                    w_state_nxt   = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin_cnt <= '0;
            r_max_pwr <= '0;
            r_max_idx <= '0;
            r_freq    <= '0;
            r_done    <= 1'b0;
            r_drop    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_bin_cnt <= w_bin_cnt_nxt;
            r_max_pwr <= w_max_pwr_nxt;
            r_max_idx <= w_max_idx_nxt;
            r_freq    <= w_freq_nxt;
            r_done    <= w_done_nxt;
            r_drop    <= w_drop_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Frame is sampled only when a new frame is accepted; later input changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_BINS; k++) begin
                r_frame[k] <= '0;
            end
        end else if (w_capture) begin
            for (int k = 0; k < NUM_BINS; k++) begin
                r_frame[k] <= w_in_words[k];
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.freq = r_freq;
    assign bus.drop = r_drop;
endmodule

// File: tb/tb_fft_peak_analyzer.sv
// Directed plus randomized checks of fft_peak_analyzer against a plain-arithmetic peak model.
module tb_fft_peak_analyzer;
    typedef logic [31:0] frame_t [16];

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fft_peak_analyzer_if ifc ();

    fft_peak_analyzer dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_frame(input frame_t f, input logic v);
        ifc.fft_valid = v;
        ifc.fft_d0  = f[0];  ifc.fft_d1  = f[1];  ifc.fft_d2  = f[2];  ifc.fft_d3  = f[3];
        ifc.fft_d4  = f[4];  ifc.fft_d5  = f[5];  ifc.fft_d6  = f[6];  ifc.fft_d7  = f[7];
        ifc.fft_d8  = f[8];  ifc.fft_d9  = f[9];  ifc.fft_d10 = f[10]; ifc.fft_d11 = f[11];
        ifc.fft_d12 = f[12]; ifc.fft_d13 = f[13]; ifc.fft_d14 = f[14]; ifc.fft_d15 = f[15];
    endtask

    task automatic zero_frame(output frame_t f);
        for (int k = 0; k < 16; k++) f[k] = 32'h0;
    endtask

    task automatic one_hot(input int k, input logic [31:0] w, output frame_t f);
        zero_frame(f);
        f[k] = w;
    endtask

    // mode 0: full random, 1: tiny values (many ties), 2: sparse random bins
    task automatic rand_frame(input int mode, output frame_t f);
        logic [15:0] re;
        logic [15:0] im;
        zero_frame(f);
        for (int k = 0; k < 16; k++) begin
            case (mode)
                0: f[k] = $urandom;
                1: begin
                    re = 16'($urandom_range(0, 3));
                    im = 16'($urandom_range(0, 3));
                    if ($urandom_range(0, 1) == 1) re = -re;
                    if ($urandom_range(0, 1) == 1) im = -im;
                    f[k] = {re, im};
                end
                default: if ($urandom_range(0, 5) == 0) f[k] = $urandom;
            endcase
        end
    endtask

    // Reference: largest re^2+im^2, first index wins ties.
    function automatic int ref_peak(input frame_t f);
        longint best = -1;
        int     idx  = 0;
        longint re, im, p;
        for (int k = 0; k < 16; k++) begin
            re = longint'($signed(f[k][31:16]));
            im = longint'($signed(f[k][15:0]));
            p  = re * re + im * im;
            if (p > best) begin
                best = p;
                idx  = k;
            end
        end
        return idx;
    endfunction

    // Called at the negedge where a frame was just driven; returns at the negedge showing done.
    task automatic analyse(input string tag, input int exp_idx, input int drop_at, input frame_t drop_f);
        int     busy_cnt = 0;
        int     done_cnt = 0;
        int     drop_cnt = 0;
        int     drop_pos = -1;
        frame_t junk;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            if (ifc.busy === 1'b1) busy_cnt++;
            if (i < 17 && ifc.done !== 1'b0) done_cnt++;
            if (ifc.drop === 1'b1) begin
                drop_cnt++;
                drop_pos = i;
            end
            if (i == drop_at) begin
                set_frame(drop_f, 1'b1);
            end else if (i < 17) begin
                rand_frame(0, junk);
                set_frame(junk, 1'b0);
            end else begin
                ifc.fft_valid = 1'b0;
            end
        end
        chk({tag, "_early_done"}, done_cnt, 0);
        chk({tag, "_done"}, ifc.done, 1);
        chk({tag, "_busy_at_done"}, ifc.busy, 0);
        chk({tag, "_busy_cycles"}, busy_cnt, 16);
        chk({tag, "_freq"}, ifc.freq, exp_idx);
        chk({tag, "_drops"}, drop_cnt, (drop_at > 0) ? 1 : 0);
        if (drop_at > 0) chk({tag, "_drop_pos"}, drop_pos, drop_at + 1);
    endtask

    task automatic idle_check(input string tag, input int exp_freq, input int n);
        int bad = 0;
        ifc.fft_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (ifc.done !== 1'b0 || ifc.drop !== 1'b0 || ifc.busy !== 1'b0) bad++;
            if (ifc.freq !== 4'(exp_freq)) bad++;
        end
        chk({tag, "_idle_hold"}, bad, 0);
    endtask

    initial begin
        frame_t f;
        frame_t fb;
        frame_t zf;
        int     exp;
        int     dat;

        zero_frame(zf);
        rst = 1'b1;
        set_frame(zf, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("reset_busy", ifc.busy, 0);
        chk("reset_done", ifc.done, 0);
        chk("reset_drop", ifc.drop, 0);
        chk("reset_freq", ifc.freq, 0);
        rst = 1'b0;
        @(negedge clk);

        one_hot(5, 32'h0064_0000, f);
        set_frame(f, 1'b1);
        analyse("single", 5, 0, zf);
        idle_check("single", 5, 3);

        set_frame(zf, 1'b1);
        analyse("allzero", 0, 0, zf);
        idle_check("allzero", 0, 3);

        zero_frame(f);
        f[3] = 32'h0010_0010; f[12] = 32'h0010_0010; f[7] = 32'h0016_0000;
        set_frame(f, 1'b1);
        analyse("tie", 3, 0, zf);
        idle_check("tie", 3, 2);

        zero_frame(f);
        f[2] = 32'h7FFF_7FFF; f[9] = 32'h8000_8000;
        set_frame(f, 1'b1);
        analyse("extreme", 9, 0, zf);
        idle_check("extreme", 9, 2);

        one_hot(4, 32'h0100_0000, f);
        one_hot(10, 32'h0200_0000, fb);
        set_frame(f, 1'b1);
        analyse("ovr_a", 4, 6, fb);
        set_frame(fb, 1'b1);
        analyse("ovr_b", 10, 0, zf);
        idle_check("ovr_b", 10, 2);

        one_hot(3, 32'h0300_0000, f);
        set_frame(f, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ifc.fft_valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("midrst_busy", ifc.busy, 0);
        chk("midrst_done", ifc.done, 0);
        chk("midrst_freq", ifc.freq, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_check("midrst_nodone", 0, 20);

        one_hot(1, 32'h0000_0500, f);
        set_frame(f, 1'b1);
        analyse("after_rst", 1, 0, zf);
        idle_check("after_rst", 1, 2);

        exp = 1;
        for (int r = 0; r < 24; r++) begin
            rand_frame(r % 3, f);
            rand_frame(0, fb);
            exp = ref_peak(f);
            dat = (r % 4 == 1) ? int'($urandom_range(1, 15)) : 0;
            set_frame(f, 1'b1);
            analyse($sformatf("rnd%0d", r), exp, dat, fb);
            if (r % 2 == 1) idle_check($sformatf("rnd%0d", r), exp, 2);
        end
        idle_check("final", exp, 3);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule

// File: doc/fft_peak_analyzer.md
FFT_PEAK_ANALYZER -- requirements
Module: fft_peak_analyzer

Interface
REQ-001 The block SHALL have no parameters; all widths below are fixed.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 fft_valid  input  1  one-cycle strobe; fft_d0..fft_d15 carry one complete 16-bin frame in that cycle.
REQ-005 fft_d0..fft_d15  input  32 each  bin k word; [31:16] = real part, [15:0] = imaginary part, each two's-complement signed 16-bit.
REQ-006 busy  output  1  high while a frame is held or being analysed.
REQ-007 done  output  1  one-cycle strobe; freq is valid for the new frame.
REQ-008 freq  output  4  index (0..15) of the bin with the largest power in the last completed frame.
REQ-009 drop  output  1  one-cycle strobe; a fft_valid arrived while busy and was discarded.

Function
REQ-010 The block SHALL implement states IDLE and CALC.
REQ-011 In IDLE, the edge sampling fft_valid=1 (E0) SHALL capture all 16 words into an internal frame register, clear the bin counter to 0, and enter CALC.
REQ-012 In IDLE with fft_valid=0, the block SHALL hold all state; done and drop SHALL be 0.
REQ-013 In CALC, one bin per edge SHALL be processed in index order 0..15: bin k at edge E(k+1).
REQ-014 Bin power SHALL be re*re + im*im.
REQ-015 Power SHALL be computed as an unsigned 32-bit value with no truncation; the maximum 2^31 (both parts -32768) SHALL be representable.
REQ-016 A running maximum SHALL be reset to the bin 0 power with index 0.
REQ-017 For k>0, the running maximum SHALL update only when the bin power is strictly greater than the stored maximum, so ties resolve to the lowest index.
REQ-018 At edge E16 (bin 15 processed, its comparison included), freq SHALL be registered with the winning index, done SHALL be 1 for the following cycle only, and the state SHALL return to IDLE.
REQ-019 Latency SHALL be exactly 16 clock edges from the edge sampling fft_valid to the edge asserting done.
REQ-020 busy SHALL be 1 from after E0 through E16 exclusive; it SHALL be 0 in the cycle in which done is 1.
REQ-021 fft_valid=1 sampled while in CALC SHALL NOT alter the frame register or the analysis, and SHALL set drop=1 for exactly the next cycle.
REQ-022 fft_valid=1 sampled in the cycle in which done=1 (state IDLE) SHALL be accepted as a new frame (back-to-back frames every 17 cycles).
REQ-023 freq SHALL hold its value between done strobes; it SHALL change only at the edge asserting done.
REQ-024 Input words SHALL be used only from the frame register after E0; changes to fft_d* after E0 SHALL have no effect.

Reset
REQ-025 rst=1 SHALL asynchronously force state IDLE, busy=0, done=0, drop=0, freq=0, bin counter=0, running maximum=0 and frame register=0.
REQ-026 rst asserted during CALC SHALL abandon the frame; no done SHALL be produced for it.
REQ-027 The first fft_valid after rst deasserts SHALL be processed normally.

Verification
REQ-028 Single peak: bin 5 = 0x00640000 (re 100, im 0), all other bins 0 -> done exactly 16 edges after fft_valid edge, freq=5; busy high 16 cycles.
REQ-029 All-zero frame -> freq=0 (tie to lowest index), done asserted once.
REQ-030 Ties and near-miss: bins 3 and 12 = 0x00100010 (power 512), bin 7 = 0x00160000 (power 484) -> freq=3.
REQ-031 Extremes: bin 2 = 0x7FFF7FFF, bin 9 = 0x80008000 (power 2^31) -> freq=9, no wrap.
REQ-032 Overrun: frame A (peak bin 4); fft_valid with peak-bin-10 frame 6 cycles later -> drop=1 one cycle, done yields freq=4. Then frame B (peak bin 10) in the done cycle -> accepted, done 16 edges later with freq=10.
REQ-033 Reset mid-operation: assert rst 8 cycles into CALC -> busy=0, freq=0, done=0 immediately; no done afterward. The next frame (peak bin 1) -> freq=1.
